// File: rtl/fpcvt_pkg.sv
// Shared definitions for the linear-to-float converter and the float decoder:
// default field widths, the packed float word and the decoder state encoding.
package fpcvt_pkg;

    localparam int FP_EXP_W = 3;
    localparam int FP_SIG_W = 4;
    localparam int FP_OUT_W = 12;
    localparam int FP_W     = 1 + FP_EXP_W + FP_SIG_W;

    // Float word layout, sign at the MSB.
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_SIG_W-1:0] sig;
    } fp_word_t;

    // Decoder control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_decode_if.sv
// Input and output valid/ready channels of the float decoder.
// The producer/consumer side uses the master modport, the decoder the slave.
interface fp_decode_if #(
    parameter int EXP_W = fpcvt_pkg::FP_EXP_W,
    parameter int SIG_W = fpcvt_pkg::FP_SIG_W,
    parameter int OUT_W = fpcvt_pkg::FP_OUT_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [EXP_W+SIG_W:0]     in_fp;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_fp,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_fp,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/fp_decode_shift.sv
// Magnitude/count register of the decoder: loads the zero-extended significand
// and exponent, shifts the magnitude left one bit per cycle while counting the
// exponent down, and flags when the count has reached zero.
module fp_decode_shift #(
    parameter int EXP_W = fpcvt_pkg::FP_EXP_W,
    parameter int SIG_W = fpcvt_pkg::FP_SIG_W,
    parameter int OUT_W = fpcvt_pkg::FP_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [EXP_W-1:0] i_cnt,
    input  logic [SIG_W-1:0] i_sig,
    output logic [OUT_W-2:0] o_mag,
    output logic             o_zero
);
    logic [EXP_W-1:0] r_cnt;
    logic [OUT_W-2:0] r_mag;

    // Load on accept, otherwise shift one place per cycle while count remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_mag <= '0;
        end else if (i_load) begin
            r_cnt <= i_cnt;
            r_mag <= {{(OUT_W-1-SIG_W){1'b0}}, i_sig};
        end else if (i_shift) begin
            r_cnt <= r_cnt - 1'b1;
            r_mag <= r_mag << 1;
        end
    end

    assign o_mag  = r_mag;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/fp_decode.sv
// Iterative float-to-linear decoder: accepts {S,E,F}, shifts F left E times
// (one bit per cycle) and presents (-1)^S * F * 2^E as a signed OUT_W value.
// OUT_W must be at least SIG_W + 2^EXP_W so the magnitude never overflows.
module fp_decode
    import fpcvt_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int SIG_W = FP_SIG_W,
    parameter int OUT_W = FP_OUT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_decode_if.slave  bus
);
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sign;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;

    logic                    w_in_ready;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_fmt;
    logic                    w_zero;
    logic [OUT_W-2:0]        w_mag;
    logic                    w_in_sign;
    logic [EXP_W-1:0]        w_in_exp;
    logic [SIG_W-1:0]        w_in_sig;

    // Attach the sign to the unsigned magnitude; S=1 with zero magnitude
    // naturally yields zero, so there is no negative zero.
    function automatic logic signed [OUT_W-1:0] apply_sign(
        input logic             sign,
        input logic [OUT_W-2:0] mag
    );
        logic signed [OUT_W-1:0] val;
        val = signed'({1'b0, mag});
        return sign ? -val : val;
    endfunction

    assign w_in_sign = bus.in_fp[EXP_W+SIG_W];
    assign w_in_exp  = bus.in_fp[EXP_W+SIG_W-1:SIG_W];
    assign w_in_sig  = bus.in_fp[SIG_W-1:0];

    fp_decode_shift #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W),
        .OUT_W (OUT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_cnt   (w_in_exp),
        .i_sig   (w_in_sig),
        .o_mag   (w_mag),
        .o_zero  (w_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-state control strobes; in_ready depends on state only.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_fmt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_zero) begin
                    w_fmt       = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_shift = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sign is captured with the word and held until formatting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_sign <= 1'b0;
        else if (w_load) r_sign <= w_in_sign;
    end

    // Registered result: set when shifting ends, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_fmt) begin
            r_out_valid <= 1'b1;
            r_out_data  <= apply_sign(r_sign, w_mag);
        end else if (r_state == ST_DONE && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
